// File: rtl/irq_ctrl.sv
// irq_ctrl - machine-mode trap sequencer between execute and the CSR file.
//
// Detects mret / ecall / ebreak / enabled machine interrupts on the
// execute-stage instruction, stalls the pipeline, writes mepc, mcause and
// mstatus through a private CSR write port, then pulses a fetch redirect to
// the trap vector (or back to mepc for mret).
//
// Ports:
//   clk_i, rst_i              clock; asynchronous active-low reset
//   inst_valid_i, inst_addr_i execute-stage instruction valid / PC
//   ecall_i, ebreak_i, mret_i decoded system instructions
//   irq_ext_i/sw_i/timer_i    level-sensitive interrupt lines
//   mstatus_i, mie_i,
//   mtvec_i, mepc_i           current CSR values
//   busy_o                    pipeline stall (combinational)
//   csr_we_o/waddr_o/wdata_o  CSR write port (wins over WB while busy_o)
//   int_assert_o, int_addr_o  one-cycle redirect pulse and its target
module irq_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      inst_valid_i,
    input  logic [DATA_WIDTH-1:0]     inst_addr_i,
    input  logic                      ecall_i,
    input  logic                      ebreak_i,
    input  logic                      mret_i,
    input  logic                      irq_ext_i,
    input  logic                      irq_sw_i,
    input  logic                      irq_timer_i,
    input  logic [DATA_WIDTH-1:0]     mstatus_i,
    input  logic [DATA_WIDTH-1:0]     mie_i,
    input  logic [DATA_WIDTH-1:0]     mtvec_i,
    input  logic [DATA_WIDTH-1:0]     mepc_i,
    output logic                      busy_o,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
    output logic                      int_assert_o,
    output logic [DATA_WIDTH-1:0]     int_addr_o
);

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'('h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'('h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'('h342);

    localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL  = DATA_WIDTH'(11);
    localparam logic [DATA_WIDTH-1:0] CAUSE_EBREAK = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] CAUSE_EXT    = {1'b1, (DATA_WIDTH-1)'(11)};
    localparam logic [DATA_WIDTH-1:0] CAUSE_SW     = {1'b1, (DATA_WIDTH-1)'(3)};
    localparam logic [DATA_WIDTH-1:0] CAUSE_TIMER  = {1'b1, (DATA_WIDTH-1)'(7)};

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MSTATUS,
        W_MRET
    } state_t;

    state_t state_q, state_d;

    // epc_q holds the trapping PC for a trap, or mepc for an mret; the two
    // sequences never overlap so one register serves both.
    logic [DATA_WIDTH-1:0] epc_q;
    logic [DATA_WIDTH-1:0] cause_q;
    logic [DATA_WIDTH-1:0] mstatus_q;
    logic [DATA_WIDTH-1:0] mtvec_q;

    logic                  ev_mret;
    logic                  ev_trap;
    logic [DATA_WIDTH-1:0] ev_cause;

    logic [DATA_WIDTH-1:0] trap_mstatus;
    logic [DATA_WIDTH-1:0] mret_mstatus;
    logic [DATA_WIDTH-1:0] vec_base;
    logic [DATA_WIDTH-1:0] trap_target;

    // Only bits 3/7/11 of mie matter; the rest are deliberately ignored.
    logic unused_mie;
    assign unused_mie = ^mie_i;

    // Event detection: synchronous events beat interrupts; interrupt lines
    // are sampled live and never latched.
    always_comb begin
        ev_mret  = 1'b0;
        ev_trap  = 1'b0;
        ev_cause = '0;
        if (inst_valid_i) begin
            if (mret_i) begin
                ev_mret = 1'b1;
            end else if (ecall_i) begin
                ev_trap  = 1'b1;
                ev_cause = CAUSE_ECALL;
            end else if (ebreak_i) begin
                ev_trap  = 1'b1;
                ev_cause = CAUSE_EBREAK;
            end else if (mstatus_i[3]) begin
                if (irq_ext_i && mie_i[11]) begin
                    ev_trap  = 1'b1;
                    ev_cause = CAUSE_EXT;
                end else if (irq_sw_i && mie_i[3]) begin
                    ev_trap  = 1'b1;
                    ev_cause = CAUSE_SW;
                end else if (irq_timer_i && mie_i[7]) begin
                    ev_trap  = 1'b1;
                    ev_cause = CAUSE_TIMER;
                end
            end
        end
    end

    // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    always_comb begin
        trap_mstatus        = mstatus_q;
        trap_mstatus[7]     = mstatus_q[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = 2'b11;
    end

    // mstatus on mret: MIE <- MPIE, MPIE <- 1.
    always_comb begin
        mret_mstatus    = mstatus_q;
        mret_mstatus[3] = mstatus_q[7];
        mret_mstatus[7] = 1'b1;
    end

    // Vectored mode only offsets interrupts; modes 2/3 fall back to direct.
    // cause[29:0] << 2 is 4 * cause[30:0] truncated to the PC width.
    assign vec_base = {mtvec_q[DATA_WIDTH-1:2], 2'b00};
    always_comb begin
        trap_target = vec_base;
        if (mtvec_q[1:0] == 2'b01 && cause_q[DATA_WIDTH-1])
            trap_target = vec_base + {cause_q[DATA_WIDTH-3:0], 2'b00};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            epc_q     <= '0;
            cause_q   <= '0;
            mstatus_q <= '0;
            mtvec_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (ev_mret) begin
                    mstatus_q <= mstatus_i;
                    epc_q     <= mepc_i;
                end else if (ev_trap) begin
                    epc_q     <= inst_addr_i;
                    cause_q   <= ev_cause;
                    mstatus_q <= mstatus_i;
                    mtvec_q   <= mtvec_i;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        busy_o       = 1'b0;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        unique case (state_q)
            IDLE: begin
                // Gated by reset so every output reads 0 while rst_i is low.
                busy_o = rst_i && (ev_mret || ev_trap);
                if (ev_mret)      state_d = W_MRET;
                else if (ev_trap) state_d = W_MEPC;
            end
            W_MEPC: begin
                busy_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = epc_q;
                state_d     = W_MCAUSE;
            end
            W_MCAUSE: begin
                busy_o      = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = cause_q;
                state_d     = W_MSTATUS;
            end
            W_MSTATUS: begin
                busy_o       = 1'b1;
                csr_we_o     = 1'b1;
                csr_waddr_o  = ADDR_MSTATUS;
                csr_wdata_o  = trap_mstatus;
                int_assert_o = 1'b1;
                int_addr_o   = trap_target;
                state_d      = IDLE;
            end
            W_MRET: begin
                busy_o       = 1'b1;
                csr_we_o     = 1'b1;
                csr_waddr_o  = ADDR_MSTATUS;
                csr_wdata_o  = mret_mstatus;
                int_assert_o = 1'b1;
                int_addr_o   = epc_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a transaction-level model predicts the output
// beats of each trap/mret, checked every cycle, plus literal spot checks.
module tb_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        inst_valid_i, ecall_i, ebreak_i, mret_i;
    logic        irq_ext_i, irq_sw_i, irq_timer_i;
    logic [31:0] inst_addr_i, mstatus_i, mie_i, mtvec_i, mepc_i;
    logic        busy_o, csr_we_o, int_assert_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, int_addr_o;

    irq_ctrl #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
        .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
        .irq_ext_i(irq_ext_i), .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i),
        .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .busy_o(busy_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        busy;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        ia;
        logic [31:0] iaddr;
    } beat_t;

    int n_chk = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    int w0, r0;
    beat_t exp_q[$];
    beat_t exp_b, act_b;
    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] ra_q[$];

    // ---------------- reference model (architectural rules) ----------------
    function automatic logic [31:0] f_trap_ms(input logic [31:0] ms);
        return (ms & 32'hFFFF_E777) | 32'h0000_1800 | (ms[3] ? 32'h80 : 32'h0);
    endfunction

    function automatic logic [31:0] f_mret_ms(input logic [31:0] ms);
        return (ms & 32'hFFFF_FF77) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [31:0] f_target(input logic [31:0] tv, input logic [31:0] cause);
        logic [31:0] base;
        base = tv & 32'hFFFF_FFFC;
        if (tv[1:0] == 2'd1 && cause[31]) return base + 32'd4 * (cause & 32'h7FFF_FFFF);
        return base;
    endfunction

    function automatic beat_t f_wr(input logic [11:0] a, input logic [31:0] d,
                                   input logic ia, input logic [31:0] ta);
        beat_t b;
        b.busy = 1'b1; b.we = 1'b1; b.waddr = a; b.wdata = d; b.ia = ia; b.iaddr = ta;
        return b;
    endfunction

    // Single compare process: every cycle, the expected outputs are either
    // the next queued beat of an event in flight or a fresh detection.
    always @(negedge clk_i) begin
        logic [31:0] cause;
        logic        hit;
        if (!rst_i) begin
            exp_q.delete();
            exp_b = '0;
        end else if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
        end else begin
            exp_b = '0;
            hit   = 1'b0;
            cause = 32'd0;
            if (inst_valid_i) begin
                if (mret_i) begin
                    exp_b.busy = 1'b1;
                    exp_q.push_back(f_wr(12'h300, f_mret_ms(mstatus_i), 1'b1, mepc_i));
                end else begin
                    hit = 1'b1;
                    if (ecall_i)                                      cause = 32'd11;
                    else if (ebreak_i)                                cause = 32'd3;
                    else if (mstatus_i[3] && irq_ext_i && mie_i[11])  cause = 32'h8000_000B;
                    else if (mstatus_i[3] && irq_sw_i && mie_i[3])    cause = 32'h8000_0003;
                    else if (mstatus_i[3] && irq_timer_i && mie_i[7]) cause = 32'h8000_0007;
                    else hit = 1'b0;
                    if (hit) begin
                        exp_b.busy = 1'b1;
                        exp_q.push_back(f_wr(12'h341, inst_addr_i, 1'b0, 32'd0));
                        exp_q.push_back(f_wr(12'h342, cause, 1'b0, 32'd0));
                        exp_q.push_back(f_wr(12'h300, f_trap_ms(mstatus_i), 1'b1,
                                             f_target(mtvec_i, cause)));
                    end
                end
            end
        end
        act_b = {busy_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o};
        n_chk++;
        if (act_b !== exp_b) begin
            n_fail++;
            $display("FAIL cycle t=%0t: got busy=%b we=%b a=%h d=%h ia=%b ta=%h, expected busy=%b we=%b a=%h d=%h ia=%b ta=%h",
                     $time, act_b.busy, act_b.we, act_b.waddr, act_b.wdata, act_b.ia, act_b.iaddr,
                     exp_b.busy, exp_b.we, exp_b.waddr, exp_b.wdata, exp_b.ia, exp_b.iaddr);
        end
        if (busy_o) busy_cnt++;
        if (csr_we_o) begin wa_q.push_back(csr_waddr_o); wd_q.push_back(csr_wdata_o); end
        if (int_assert_o) ra_q.push_back(int_addr_o);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_wr(input string nm, input int idx, input logic [11:0] a, input logic [31:0] d);
        if (idx >= wa_q.size()) begin
            n_chk++; n_fail++;
            $display("FAIL %s: write %0d missing, expected %h <- %h", nm, idx, a, d);
        end else begin
            chk({nm, " addr"}, {20'd0, wa_q[idx]}, {20'd0, a});
            chk({nm, " data"}, wd_q[idx], d);
        end
    endtask

    task automatic chk_rd(input string nm, input int idx, input logic [31:0] ta);
        if (idx >= ra_q.size()) begin
            n_chk++; n_fail++;
            $display("FAIL %s: redirect %0d missing, expected %h", nm, idx, ta);
        end else chk(nm, ra_q[idx], ta);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic ec, input logic eb, input logic mr,
                         input logic ext, input logic sw, input logic tm,
                         input logic [31:0] pc, input logic [31:0] ms, input logic [31:0] ie,
                         input logic [31:0] tv, input logic [31:0] ep);
        inst_valid_i = v; ecall_i = ec; ebreak_i = eb; mret_i = mr;
        irq_ext_i = ext; irq_sw_i = sw; irq_timer_i = tm;
        inst_addr_i = pc; mstatus_i = ms; mie_i = ie; mtvec_i = tv; mepc_i = ep;
    endtask

    task automatic idle_flush();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1);
    endtask

    task automatic mark();
        w0 = wa_q.size(); r0 = ra_q.size(); busy_cnt = 0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("reset busy",   {31'd0, busy_o}, 32'd0);
        chk("reset we",     {31'd0, csr_we_o}, 32'd0);
        chk("reset wdata",  csr_wdata_o, 32'd0);
        chk("reset assert", {31'd0, int_assert_o}, 32'd0);
        chk("reset addr",   int_addr_o, 32'd0);
        step(2);
        rst_i = 1'b1;
        step(1);

        // Timer interrupt, direct mode.
        mark();
        drive(1, 0, 0, 0, 0, 0, 1, 32'h2C, 32'h8, 32'h80, 32'h100, 32'h0);
        step(4);
        idle_flush();
        chk_wr("timer mepc", w0, 12'h341, 32'h2C);
        chk_wr("timer mcause", w0 + 1, 12'h342, 32'h8000_0007);
        chk_wr("timer mstatus", w0 + 2, 12'h300, 32'h1880);
        chk_rd("timer target", r0, 32'h100);
        chk("timer busy cycles", busy_cnt, 4);

        // ecall with vectored mtvec: exceptions go to base.
        mark();
        drive(1, 1, 0, 0, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h201, 32'h0);
        step(4);
        idle_flush();
        chk_wr("ecall mcause", w0 + 1, 12'h342, 32'd11);
        chk_wr("ecall mstatus", w0 + 2, 12'h300, 32'h1800);
        chk_rd("ecall target", r0, 32'h200);

        // ext + timer pending, vectored: ext wins.
        mark();
        drive(1, 0, 0, 0, 1, 0, 1, 32'h50, 32'h8, 32'h880, 32'h301, 32'h0);
        step(4);
        idle_flush();
        chk_wr("ext mcause", w0 + 1, 12'h342, 32'h8000_000B);
        chk_rd("ext target", r0, 32'h32C);
        // mret with timer still pending but MIE cleared by the trap.
        mark();
        drive(1, 0, 0, 1, 0, 0, 1, 32'h58, 32'h1880, 32'h880, 32'h301, 32'h50);
        step(2);
        idle_flush();
        chk_wr("ext mret mstatus", w0, 12'h300, 32'h1888);
        chk_rd("ext mret target", r0, 32'h50);
        // MIE restored: timer now taken.
        mark();
        drive(1, 0, 0, 0, 0, 0, 1, 32'h50, 32'h1888, 32'h880, 32'h301, 32'h50);
        step(4);
        idle_flush();
        chk_wr("late timer mcause", w0 + 1, 12'h342, 32'h8000_0007);
        chk_rd("late timer target", r0, 32'h31C);

        // Plain mret.
        mark();
        drive(1, 0, 0, 1, 0, 0, 0, 32'h90, 32'h1880, 32'h0, 32'h0, 32'h2C);
        step(2);
        idle_flush();
        chk_wr("mret mstatus", w0, 12'h300, 32'h1888);
        chk_rd("mret target", r0, 32'h2C);
        chk("mret busy cycles", busy_cnt, 2);
        chk("mret write count", wa_q.size() - w0, 1);

        // Ignored events: MIE=0, mie bit clear, ecall without valid.
        mark();
        drive(1, 0, 0, 0, 0, 0, 1, 32'h60, 32'h0, 32'h80, 32'h100, 32'h0);
        step(3);
        drive(1, 0, 0, 0, 0, 0, 1, 32'h60, 32'h8, 32'h800, 32'h100, 32'h0);
        step(3);
        drive(0, 1, 0, 0, 0, 0, 0, 32'h60, 32'h8, 32'h0, 32'h100, 32'h0);
        step(3);
        idle_flush();
        chk("ignored busy cycles", busy_cnt, 0);
        chk("ignored writes", wa_q.size() - w0, 0);

        // Everything at once: mret beats ecall/ebreak/irq.
        mark();
        drive(1, 1, 1, 1, 1, 0, 0, 32'h70, 32'h8, 32'h800, 32'h100, 32'h100);
        step(2);
        idle_flush();
        chk_wr("all mret mstatus", w0, 12'h300, 32'h80);
        chk_rd("all mret target", r0, 32'h100);
        // ecall beats ebreak and irq; then ebreak beats irq.
        mark();
        drive(1, 1, 1, 0, 1, 0, 0, 32'h74, 32'h8, 32'h800, 32'h301, 32'h0);
        step(4);
        idle_flush();
        drive(1, 0, 1, 0, 1, 0, 0, 32'h78, 32'h8, 32'h800, 32'h301, 32'h0);
        step(4);
        idle_flush();
        chk_wr("ecall prio mcause", w0 + 1, 12'h342, 32'd11);
        chk_wr("ebreak prio mcause", w0 + 4, 12'h342, 32'd3);
        chk_rd("ebreak target", r0 + 1, 32'h300);

        // sw beats timer; vectored target.
        mark();
        drive(1, 0, 0, 0, 0, 1, 1, 32'h80, 32'h8, 32'h88, 32'h301, 32'h0);
        step(4);
        idle_flush();
        chk_rd("sw target", r0, 32'h30C);
        // Vectored target wraps past the top of the address space.
        mark();
        drive(1, 0, 0, 0, 1, 0, 0, 32'h84, 32'h8, 32'h800, 32'hFFFF_FFF1, 32'h0);
        step(4);
        idle_flush();
        chk_rd("wrap target", r0, 32'h1C);
        // mtvec mode 3 behaves as direct.
        mark();
        drive(1, 0, 0, 0, 0, 0, 1, 32'h88, 32'h8, 32'h80, 32'h103, 32'h0);
        step(4);
        idle_flush();
        chk_rd("mode3 target", r0, 32'h100);

        // Reset asserted while the mcause write is on the port.
        mark();
        drive(1, 1, 0, 0, 0, 0, 0, 32'h8C, 32'h8, 32'h0, 32'h100, 32'h0);
        step(2);
        #6;
        rst_i = 1'b0;
        #1;
        chk("midreset we", {31'd0, csr_we_o}, 32'd0);
        chk("midreset busy", {31'd0, busy_o}, 32'd0);
        chk("midreset wdata", csr_wdata_o, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(2);
        rst_i = 1'b1;
        step(1);
        chk("midreset writes", wa_q.size() - w0, 2);
        chk("midreset redirects", ra_q.size() - r0, 0);
        mark();
        drive(1, 1, 0, 0, 0, 0, 0, 32'h94, 32'h8, 32'h0, 32'h100, 32'h0);
        step(4);
        idle_flush();
        chk_wr("post reset mepc", w0, 12'h341, 32'h94);
        chk_wr("post reset mstatus", w0 + 2, 12'h300, 32'h1880);
        chk_rd("post reset target", r0, 32'h100);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
